// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 keyboard slave: bus geometry, register map,
// STATUS bit layout and PS/2 frame shape.
package kbd_pkg;
    localparam int KBD_XLEN        = 32;
    localparam int KBD_SLAVE_WIDTH = 4;

    localparam logic [2:0] KBD_DATA   = 3'h0;
    localparam logic [2:0] KBD_STATUS = 3'h4;

    localparam int ST_NONEMPTY  = 0;
    localparam int ST_OVERFLOW  = 1;
    localparam int ST_PARERR    = 2;
    localparam int ST_COUNT_LSB = 4;

    localparam int         PS2_FRAME_LEN = 11;
    localparam logic [3:0] PS2_PAR_BIT   = 4'(PS2_FRAME_LEN - 2);
    localparam logic [3:0] PS2_STOP_BIT  = 4'(PS2_FRAME_LEN - 1);

    // Odd parity: data ones plus parity bit must total an odd number.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction
endpackage

// File: rtl/ps2_rx.sv
// PS/2 line synchroniser and 11-bit frame shifter. Emits a one-cycle done
// pulse at the stop bit together with stop/parity status and the data byte.
module ps2_rx
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_stop_ok,
    output logic       rx_par_ok,
    output logic [3:0] bitcnt
);
    logic [2:0] clk_sync;
    logic [2:0] dat_sync;
    logic       fall;
    logic       bit_in;
    logic [7:0] shift;
    logic       par_bit;

    // Sync chains idle high so reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 3'b111;
            dat_sync <= 3'b111;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
        end
    end

    assign fall   = (clk_sync[2:1] == 2'b10);
    assign bit_in = dat_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt     <= 4'd0;
            shift      <= 8'd0;
            par_bit    <= 1'b0;
            rx_byte    <= 8'd0;
            rx_done    <= 1'b0;
            rx_stop_ok <= 1'b0;
            rx_par_ok  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (fall) begin
                if (bitcnt == 4'd0) begin
                    if (!bit_in) bitcnt <= 4'd1;
                end else if (bitcnt == PS2_STOP_BIT) begin
                    bitcnt     <= 4'd0;
                    rx_done    <= 1'b1;
                    rx_stop_ok <= bit_in;
                    rx_byte    <= shift;
                    rx_par_ok  <= odd_parity_ok(shift, par_bit);
                end else if (bitcnt == PS2_PAR_BIT) begin
                    par_bit <= bit_in;
                    bitcnt  <= bitcnt + 4'd1;
                end else begin
                    shift  <= {bit_in, shift[7:1]};
                    bitcnt <= bitcnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/ps2_keyboard_slave.sv
// PS/2 keyboard bus slave: scan-code FIFO, DATA/STATUS registers, 1-cycle
// ready handshake. Define KBD_PARITY_CHECK_EN to drop bad-parity frames.
module ps2_keyboard_slave
    import kbd_pkg::*;
#(
    parameter int XLEN        = KBD_XLEN,
    parameter int SLAVE_WIDTH = KBD_SLAVE_WIDTH,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        slave_req,
    input  logic                        slave_wen,
    input  logic [XLEN-SLAVE_WIDTH-1:0] slave_addr,
    input  logic [2:0]                  slave_mode,
    input  logic [XLEN-1:0]             slave_dat_i,
    output logic [XLEN-1:0]             slave_dat_o,
    output logic                        slave_ready,
    output logic                        overflow_o,
    output logic [7:0]                  keycode_o,
    output logic [3:0]                  state_o
);
    localparam int         PW    = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       rx_done, rx_stop_ok, rx_par_ok;

    ps2_rx u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .rx_stop_ok (rx_stop_ok),
        .rx_par_ok  (rx_par_ok),
        .bitcnt     (state_o)
    );

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [PW:0]     count;
    logic            empty, full, frame_ok, push, pop;
    logic            accept, is_data, is_status, wr_status;
    logic [2:0]      reg_off;
    logic [XLEN-1:0] status_word, rd_word;

    assign accept    = slave_req & ~slave_ready;
    assign reg_off   = {slave_addr[2], 2'b00};
    assign is_data   = (reg_off == KBD_DATA);
    assign is_status = (reg_off == KBD_STATUS);
    assign wr_status = accept & slave_wen & is_status;

    assign empty = (count == '0);
    assign full  = (count == DEPTH);
    assign pop   = accept & ~slave_wen & is_data & ~empty;
    // Pop frees a slot in the same cycle, so full+pop+push still lands.
    assign push  = frame_ok & (~full | pop);

`ifdef KBD_PARITY_CHECK_EN
    logic par_err;
    assign frame_ok = rx_done & rx_stop_ok & rx_par_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        par_err <= 1'b0;
        else if (rx_done & ~rx_par_ok)   par_err <= 1'b1;
        else if (wr_status)              par_err <= 1'b0;
    end
`else
    assign frame_ok = rx_done & rx_stop_ok;
`endif

    always_comb begin
        status_word                    = '0;
        status_word[ST_COUNT_LSB +: 8] = 8'(count);
        status_word[ST_OVERFLOW]       = overflow_o;
        status_word[ST_NONEMPTY]       = ~empty;
`ifdef KBD_PARITY_CHECK_EN
        status_word[ST_PARERR]         = par_err;
`endif
    end

    always_comb begin
        rd_word = '0;
        if (is_status)   rd_word = status_word;
        else if (!empty) rd_word = XLEN'(mem[rd_ptr]);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            keycode_o  <= 8'd0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (push & ~pop)      count <= count + (PW+1)'(1);
            else if (pop & ~push) count <= count - (PW+1)'(1);
            if (frame_ok) keycode_o <= rx_byte;
            if (frame_ok & full & ~pop) overflow_o <= 1'b1;
            else if (wr_status)         overflow_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slave_ready <= 1'b0;
            slave_dat_o <= '0;
        end else begin
            slave_ready <= accept;
            if (accept) slave_dat_o <= slave_wen ? '0 : rd_word;
        end
    end

    logic unused_bits;
`ifdef KBD_PARITY_CHECK_EN
    assign unused_bits = ^{slave_mode, slave_dat_i, slave_addr[XLEN-SLAVE_WIDTH-1:3],
                           slave_addr[1:0]};
`else
    assign unused_bits = ^{slave_mode, slave_dat_i, slave_addr[XLEN-SLAVE_WIDTH-1:3],
                           slave_addr[1:0], rx_par_ok};
`endif
endmodule

// File: tb/tb_ps2_keyboard_slave.sv
// Bench for ps2_keyboard_slave: table of directed vectors, hand sequences for
// overflow/start error/parity/reset, then random traffic against a queue model.
module tb_ps2_keyboard_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        slave_req = 1'b0;
    logic        slave_wen = 1'b0;
    logic [27:0] slave_addr = '0;
    logic [2:0]  slave_mode = '0;
    logic [31:0] slave_dat_i = '0;
    logic [31:0] slave_dat_o;
    logic        slave_ready;
    logic        overflow_o;
    logic [7:0]  keycode_o;
    logic [3:0]  state_o;

    ps2_keyboard_slave dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .slave_req(slave_req), .slave_wen(slave_wen), .slave_addr(slave_addr),
        .slave_mode(slave_mode), .slave_dat_i(slave_dat_i), .slave_dat_o(slave_dat_o),
        .slave_ready(slave_ready), .overflow_o(overflow_o), .keycode_o(keycode_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: plain byte queue plus sticky flags.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_perr = 1'b0;
    logic [7:0] m_key = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (4) tick();
        ps2_clk = 1'b0;
        repeat (8) tick();
        ps2_clk = 1'b1;
        repeat (4) tick();
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_start,
                                               input logic bad_par, input logic bad_stop);
        logic [10:0] f;
        f[0]   = bad_start;
        f[8:1] = d;
        f[9]   = ~(^d) ^ bad_par;
        f[10]  = ~bad_stop;
        return f;
    endfunction

    task automatic model_frame(input logic [7:0] d, input logic bad_start,
                               input logic bad_par, input logic bad_stop);
        logic accept_byte;
        accept_byte = !bad_start && !bad_stop;
`ifdef KBD_PARITY_CHECK_EN
        if (accept_byte && bad_par) begin
            m_perr = 1'b1;
            accept_byte = 1'b0;
        end
`endif
        if (accept_byte) begin
            m_key = d;
            if (q.size() < 16) q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_start,
                              input logic bad_par, input logic bad_stop);
        logic [10:0] f;
        f = make_frame(d, bad_start, bad_par, bad_stop);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (4) tick();
        model_frame(d, bad_start, bad_par, bad_stop);
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[11:4] = 8'(q.size());
        s[2] = m_perr;
        s[1] = m_ovf;
        s[0] = (q.size() != 0);
        return s;
    endfunction

    // One bus access; checks one-cycle latency and a single ready pulse.
    task automatic bus(input logic wen, input logic [2:0] off, output logic [31:0] rdat);
        int lat;
        lat = 0;
        slave_req   = 1'b1;
        slave_wen   = wen;
        slave_addr  = 28'($urandom);
        slave_addr[2] = off[2];
        slave_mode  = 3'($urandom);
        slave_dat_i = $urandom;
        do begin
            tick();
            lat++;
        end while (!slave_ready && lat < 8);
        check("ready_latency", lat, 1);
        rdat = slave_dat_o;
        slave_req = 1'b0;
        tick();
        check("ready_single_pulse", {31'b0, slave_ready}, 0);
    endtask

    task automatic rd_data_model();
        logic [31:0] r, e;
        e = (q.size() != 0) ? {24'b0, q.pop_front()} : 32'h0;
        bus(1'b0, 3'h0, r);
        check("data_read", r, e);
    endtask

    task automatic rd_status_model();
        logic [31:0] r, e;
        e = model_status();
        bus(1'b0, 3'h4, r);
        check("status_read", r, e);
    endtask

    task automatic wr_reg(input logic [2:0] off);
        logic [31:0] r;
        bus(1'b1, off, r);
        check("write_ack_data", r, 0);
        if (off == 3'h4) begin
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end
    endtask

    typedef struct {
        int          op;      // 0 send byte, 1 read DATA, 2 read STATUS
        logic [7:0]  b;
        logic [31:0] exp;
        logic [7:0]  exp_key;
    } vec_t;

    vec_t vt[9];

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        vt[0] = '{0, 8'h1C, 32'h0,   8'h1C};
        vt[1] = '{1, 8'h00, 32'h1C,  8'h1C};
        vt[2] = '{1, 8'h00, 32'h0,   8'h1C};
        vt[3] = '{0, 8'hF0, 32'h0,   8'hF0};
        vt[4] = '{0, 8'h1C, 32'h0,   8'h1C};
        vt[5] = '{2, 8'h00, 32'h21,  8'h1C};
        vt[6] = '{1, 8'h00, 32'hF0,  8'h1C};
        vt[7] = '{1, 8'h00, 32'h1C,  8'h1C};
        vt[8] = '{2, 8'h00, 32'h0,   8'h1C};

        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        check("reset_ready", {31'b0, slave_ready}, 0);
        check("reset_dat_o", slave_dat_o, 0);
        check("reset_overflow", {31'b0, overflow_o}, 0);
        check("reset_keycode", {24'b0, keycode_o}, 0);
        check("reset_state", {28'b0, state_o}, 0);

        // Directed table: single byte, two-byte ordering, status counts.
        for (int i = 0; i < 9; i++) begin
            if (vt[i].op == 0) begin
                send_frame(vt[i].b, 1'b0, 1'b0, 1'b0);
            end else begin
                bus(1'b0, (vt[i].op == 2) ? 3'h4 : 3'h0, r);
                check("table_read", r, vt[i].exp);
                if (vt[i].op == 1 && q.size() != 0) void'(q.pop_front());
            end
            check("table_keycode", {24'b0, keycode_o}, {24'b0, vt[i].exp_key});
        end

        // Overflow: 17 bytes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        check("ovf_flag", {31'b0, overflow_o}, 1);
        bus(1'b0, 3'h4, r);
        check("ovf_status", r, 32'h103);
        check("ovf_keycode", {24'b0, keycode_o}, 32'h40);
        for (int i = 0; i < 16; i++) begin
            bus(1'b0, 3'h0, r);
            check("ovf_fifo_byte", r, 32'(8'h30 + i));
            void'(q.pop_front());
        end
        wr_reg(3'h4);
        check("ovf_cleared", {31'b0, overflow_o}, 0);
        rd_status_model();

        // Start-bit error: an all-ones frame never starts.
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        check("badstart_state", {28'b0, state_o}, 0);
        bus(1'b0, 3'h4, r);
        check("badstart_status", r, 0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        bus(1'b0, 3'h0, r);
        check("after_badstart", r, 32'h5A);
        void'(q.pop_front());

        // Bad parity on 0x29.
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        bus(1'b0, 3'h4, r);
`ifdef KBD_PARITY_CHECK_EN
        check("badpar_status", r, 32'h4);
        check("badpar_keycode", {24'b0, keycode_o}, 32'h5A);
        rd_data_model();
        wr_reg(3'h4);
        rd_status_model();
`else
        check("badpar_status", r, 32'h11);
        check("badpar_keycode", {24'b0, keycode_o}, 32'h29);
        bus(1'b0, 3'h0, r);
        check("badpar_data", r, 32'h29);
        void'(q.pop_front());
`endif

        // Reset mid-frame and mid-access.
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        begin
            logic [10:0] f;
            f = make_frame(8'hA5, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        end
        check("midframe_state", {28'b0, state_o}, 5);
        slave_wen = 1'b0;
        slave_addr = '0;
        slave_req = 1'b1;
        tick();
        check("midaccess_ready", {31'b0, slave_ready}, 1);
        check("midaccess_data", slave_dat_o, 32'h77);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'b0, slave_ready}, 0);
        check("rst_dat_o", slave_dat_o, 0);
        check("rst_keycode", {24'b0, keycode_o}, 0);
        check("rst_state", {28'b0, state_o}, 0);
        check("rst_overflow", {31'b0, overflow_o}, 0);
        q.delete();
        m_ovf = 1'b0;
        m_perr = 1'b0;
        m_key = 8'h00;
        slave_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("postrst_keycode", {24'b0, keycode_o}, 32'h3C);
        rd_data_model();
        rd_status_model();

        // Random traffic against the queue model.
        for (int i = 0; i < 60; i++) begin
            int sel, err;
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                err = $urandom_range(0, 7);
                send_frame(8'($urandom), 1'b0, err == 0, err == 1);
            end else if (sel <= 6) begin
                rd_data_model();
            end else if (sel == 7) begin
                rd_status_model();
            end else if (sel == 8) begin
                wr_reg(3'h4);
            end else begin
                wr_reg(3'h0);
            end
            check("rand_keycode", {24'b0, keycode_o}, {24'b0, m_key});
            check("rand_overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
        end
        rd_status_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
